cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single request port of the set-associative cache (valid/rw/addr/wdata in; ready/rdata/hit out) among NUM_REQ requesters.
- Accepts one requester transaction, issues it to the cache, waits the cache's fixed response latency, and returns rdata/hit to the owning requester.
- Keeps saturating hit and miss counters for performance monitoring.
- Sits between the core-side clients and the cache instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 16, cache address width.
- DATA_WIDTH, 32, cache data width.
- RSP_LAT, 1, cycles from the cache acceptance cycle (c_valid && c_ready) to the cycle in which c_rdata/c_hit are valid (1..4).
- CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_ready  out  NUM_REQ  one-hot, 1-cycle acceptance pulse.
- req_rw  in  NUM_REQ  per-requester direction, 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened, same packing.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle response pulse to the owner.
- rsp_rdata  out  DATA_WIDTH  shared response data, valid while any rsp_valid bit is high.
- rsp_hit  out  1  shared hit flag, same qualification.
- c_valid  out  1  request to cache.
- c_rw  out  1  direction to cache.
- c_addr  out  ADDR_WIDTH  address to cache.
- c_wdata  out  DATA_WIDTH  write data to cache.
- c_ready  in  1  cache can accept.
- c_rdata  in  DATA_WIDTH  cache read data.
- c_hit  in  1  cache hit.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner.
- busy  out  1  high in any state other than IDLE.
- hit_count  out  CNT_WIDTH  completed transactions with hit=1, saturating.
- miss_count  out  CNT_WIDTH  completed transactions with hit=0, saturating.

Behaviour:
- Reset state (rst high at an edge): state=IDLE, rr_ptr=0, grant_id=0, counters=0, and every output 0 (req_ready, rsp_valid, rsp_rdata, rsp_hit, c_valid, c_rw, c_addr, c_wdata, busy). Reset takes priority over all events.
- FSM states:
  - IDLE
    - If any req_valid is high: the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
    - req_ready[winner]=1 combinationally in this cycle only.
    - Latch winner rw/addr/wdata and grant_id=winner; go to ISSUE.
    - If no req_valid is high: stay in IDLE, all req_ready=0.
  - ISSUE
    - c_valid=1 and c_rw/c_addr/c_wdata driven from the latches; they hold stable until accepted.
    - On c_ready=1 load lat_cnt=RSP_LAT and go to WAIT. Otherwise stay in ISSUE (no timeout).
  - WAIT
    - Decrement lat_cnt each cycle. c_valid=0; c_addr/c_wdata may hold their last values.
    - When lat_cnt==1: register c_rdata/c_hit into rsp_rdata/rsp_hit and go to RESP.
  - RESP
    - rsp_valid[grant_id]=1 for exactly one cycle.
    - Increment hit_count if rsp_hit else miss_count; saturate at all-ones, no wrap.
    - rr_ptr=(grant_id+1) mod NUM_REQ. Go to IDLE.
- Latency: request seen in IDLE cycle T with c_ready=1 and RSP_LAT=1:
  - req_ready at T
  - c_valid at T+1
  - capture at T+2
  - rsp_valid at T+3
  - IDLE again at T+4
- Minimum 4 cycles per transaction; no overlap between transactions.
- Writes also report c_hit and are counted.
- Requesters that are not granted may drop or change req_valid freely. Arbitration looks only at the IDLE cycle.
- rsp_valid carries no back-pressure; requesters must sample it.
- Only one requester is outstanding at a time, so responses are in order.
- rsp_rdata/rsp_hit hold their value after RESP until the next capture.
- Reset mid-transaction: the in-flight cache response is discarded and no rsp_valid is issued.

Test Plan:
- Single read: req 2 valid, addr 0x1234, rw=0, c_ready=1, c_hit=1, c_rdata=0xDEADBEEF in the capture cycle -> req_ready=0b0100 at T, c_valid at T+1 with c_addr=0x1234, rsp_valid=0b0100 at T+3 with rsp_rdata=0xDEADBEEF and rsp_hit=1, hit_count=1.
- Round robin: all 4 requesters held valid for 16 transactions -> grant order 0,1,2,3,0,1,2,3,… and each requester granted exactly 4 times.
- Back-pressure: c_ready low for 5 cycles in ISSUE -> c_valid high and c_addr/c_wdata/c_rw constant for all 6 ISSUE cycles; rsp_valid RSP_LAT+1 cycles after the c_ready cycle.
- RSP_LAT=3 build: a write with c_hit=0 -> capture 3 cycles after acceptance, rsp_valid with rsp_hit=0, miss_count increments by 1.
- Saturation, CNT_WIDTH=4: 20 hit transactions -> hit_count stops at 15 and miss_count stays 0.
- Reset in WAIT: rst high for 1 cycle -> no rsp_valid, busy=0, counters=0, next grant starts from requester 0.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin sequencer sharing one cache request port among NUM_REQ clients.
// One transaction in flight at a time; saturating hit/miss counters.
module cache_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_LAT    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_hit,
  output logic                             c_valid,
  output logic                             c_rw,
  output logic [ADDR_WIDTH-1:0]            c_addr,
  output logic [DATA_WIDTH-1:0]            c_wdata,
  input  logic                             c_ready,
  input  logic [DATA_WIDTH-1:0]            c_rdata,
  input  logic                             c_hit,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             hit_count,
  output logic [CNT_WIDTH-1:0]             miss_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int LW  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [LW-1:0]  lat_cnt;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic           any_req;

  // First pending requester at or above rr_ptr, wrapping.
  always_comb begin
    any_req = |req_valid;
    winner  = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && any_req) req_ready[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      lat_cnt    <= '0;
      c_valid    <= 1'b0;
      c_rw       <= 1'b0;
      c_addr     <= '0;
      c_wdata    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_hit    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            c_rw     <= req_rw[winner];
            c_addr   <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            c_wdata  <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
            c_valid  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (c_ready) begin
            c_valid <= 1'b0;
            lat_cnt <= LW'(RSP_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LW'(1);
          if (lat_cnt == LW'(1)) begin
            rsp_rdata           <= c_rdata;
            rsp_hit             <= c_hit;
            rsp_valid[grant_id] <= 1'b1;
            state               <= RESP;
          end
        end
        RESP: begin
          if (rsp_hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
          end
          rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench: instance 0 has RSP_LAT=1/CNT_WIDTH=4, instance 1 RSP_LAT=3/CNT_WIDTH=16.
module tb_cache_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct {
    bit          k;
    logic [1:0]  who;
    logic        rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic        hit;
    logic [15:0] hc;
    logic [15:0] mc;
    bit          resp;
    int unsigned n_issue;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] cyc = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0][N-1:0]    req_valid, req_ready, req_rw, rsp_valid;
  logic [1:0][N*AW-1:0] req_addr;
  logic [1:0][N*DW-1:0] req_wdata;
  logic [1:0][DW-1:0]   rsp_rdata, c_wdata, c_rdata;
  logic [1:0]           rsp_hit, c_valid, c_rw, c_ready, c_hit, busy, cfg_hit;
  logic [1:0][AW-1:0]   c_addr;
  logic [1:0][1:0]      grant_id;
  logic [1:0][15:0]     hit_cnt, miss_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int CW  = (g == 0) ? 4 : 16;
    logic [CW-1:0] hc, mc;
    cache_port_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_LAT(LAT), .CNT_WIDTH(CW)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_rw(req_rw[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_hit(rsp_hit[g]),
      .c_valid(c_valid[g]), .c_rw(c_rw[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_ready(c_ready[g]), .c_rdata(c_rdata[g]), .c_hit(c_hit[g]),
      .grant_id(grant_id[g]), .busy(busy[g]),
      .hit_count(hc), .miss_count(mc)
    );
    assign hit_cnt[g]  = 16'(hc);
    assign miss_cnt[g] = 16'(mc);
  end

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 64'd1; end
  initial begin #2000000; $display("FAIL watchdog: simulation still running, expected finish"); $fatal(1); end

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return (a == 16'h1234) ? 32'hDEADBEEF : {~a, a};
  endfunction

  function automatic int unsigned lat(input bit k);
    return k ? 3 : 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  // Cache model: drives real data only in the capture cycle, junk otherwise.
  int unsigned   pend [2];
  logic [AW-1:0] acc_addr [2];
  initial begin
    pend[0] = 0; pend[1] = 0; acc_addr[0] = '0; acc_addr[1] = '0;
    c_rdata = '0; c_hit = '0;
    forever begin
      @(posedge clk);
      for (int unsigned ki = 0; ki < 2; ki++) begin
        bit k;
        k = ki[0];
        if (rst) pend[k] = 0;
        else if (c_valid[k] && c_ready[k]) begin
          pend[k] = lat(k);
          acc_addr[k] = c_addr[k];
        end else if (pend[k] > 0) pend[k]--;
      end
      #1;
      for (int unsigned ki = 0; ki < 2; ki++) begin
        bit k;
        k = ki[0];
        if (pend[k] == 1) begin
          c_rdata[k] = rd(acc_addr[k]);
          c_hit[k]   = cfg_hit[k];
        end else begin
          c_rdata[k] = 32'hBAD0BAD0;
          c_hit[k]   = ~cfg_hit[k];
        end
      end
    end
  end

  // Monitor: pops expectations on grant, checks issue and response.
  exp_t        cur [2];
  bit          have [2];
  bit          chk [2];
  logic [63:0] gcyc [2];
  int unsigned nissue [2];
  initial begin
    have[0] = 0; have[1] = 0; chk[0] = 0; chk[1] = 0;
    forever begin
      @(negedge clk);
      for (int unsigned ki = 0; ki < 2; ki++) begin
        bit k;
        k = ki[0];
        if (rst) begin
          have[k] = 0;
          chk[k]  = 0;
        end else begin
          if (chk[k]) begin
            check("hit_count", 64'(hit_cnt[k]), 64'(cur[k].hc));
            check("miss_count", 64'(miss_cnt[k]), 64'(cur[k].mc));
            chk[k] = 0;
          end
          if (req_ready[k] != '0) begin
            if (exp_q.size() == 0) flag("unexpected_grant");
            else begin
              cur[k] = exp_q.pop_front();
              check("grant_instance", 64'(k), 64'(cur[k].k));
              check("req_ready", 64'(req_ready[k]), 64'(1) << cur[k].who);
              have[k]   = 1;
              gcyc[k]   = cyc;
              nissue[k] = 0;
            end
          end
          if (c_valid[k]) begin
            if (!have[k]) flag("unexpected_c_valid");
            else begin
              check("c_rw", 64'(c_rw[k]), 64'(cur[k].rw));
              check("c_addr", 64'(c_addr[k]), 64'(cur[k].addr));
              check("c_wdata", 64'(c_wdata[k]), 64'(cur[k].wdata));
              if (nissue[k] == 0) begin
                check("issue_latency", cyc - gcyc[k], 64'd1);
                check("grant_id", 64'(grant_id[k]), 64'(cur[k].who));
              end
              nissue[k]++;
            end
          end
          if (rsp_valid[k] != '0) begin
            if (!have[k] || !cur[k].resp) flag("unexpected_rsp_valid");
            else begin
              check("rsp_valid", 64'(rsp_valid[k]), 64'(1) << cur[k].who);
              check("rsp_rdata", 64'(rsp_rdata[k]), 64'(cur[k].rdata));
              check("rsp_hit", 64'(rsp_hit[k]), 64'(cur[k].hit));
              check("issue_cycles", 64'(nissue[k]), 64'(cur[k].n_issue));
              check("rsp_latency", cyc - gcyc[k], 64'(cur[k].n_issue + lat(k) + 1));
              chk[k] = 1;
            end
            have[k] = 0;
          end
        end
      end
    end
  end

  task automatic push(input bit k, input logic [1:0] who, input logic rw, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic hit, input logic [15:0] hc,
                      input logic [15:0] mc, input bit resp, input int unsigned n_issue);
    exp_t e;
    e.k = k; e.who = who; e.rw = rw; e.addr = addr; e.wdata = wdata; e.rdata = rd(addr);
    e.hit = hit; e.hc = hc; e.mc = mc; e.resp = resp; e.n_issue = n_issue;
    exp_q.push_back(e);
  endtask

  task automatic set_slot(input bit k, input logic [1:0] who, input logic rw,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_rw[k][who] = rw;
    req_addr[k][who*AW +: AW] = addr;
    req_wdata[k][who*DW +: DW] = wdata;
  endtask

  task automatic wait_grant(input bit k);
    bit got;
    got = 0;
    for (int unsigned i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[k] != '0) got = 1;
    end
    if (!got) check("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input bit k);
    bit done;
    done = 0;
    for (int unsigned i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy[k] && exp_q.size() == 0) done = 1;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic one_txn(input bit k, input logic [1:0] who, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic hit, input logic [15:0] hc,
                         input logic [15:0] mc, input int unsigned stall);
    push(k, who, rw, addr, wdata, hit, hc, mc, 1, stall + 1);
    set_slot(k, who, rw, addr, wdata);
    cfg_hit[k] = hit;
    @(posedge clk); #1;
    c_ready[k] = (stall == 0);
    req_valid[k][who] = 1'b1;
    wait_grant(k);
    @(posedge clk); #1;
    req_valid[k] = '0;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      c_ready[k] = 1'b1;
    end
    wait_done(k);
  endtask

  task automatic check_reset(input bit k);
    check("rst_req_ready", 64'(req_ready[k]), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata[k]), 64'd0);
    check("rst_rsp_hit", 64'(rsp_hit[k]), 64'd0);
    check("rst_c_valid", 64'(c_valid[k]), 64'd0);
    check("rst_c_rw", 64'(c_rw[k]), 64'd0);
    check("rst_c_addr", 64'(c_addr[k]), 64'd0);
    check("rst_c_wdata", 64'(c_wdata[k]), 64'd0);
    check("rst_busy", 64'(busy[k]), 64'd0);
    check("rst_grant_id", 64'(grant_id[k]), 64'd0);
    check("rst_hit_count", 64'(hit_cnt[k]), 64'd0);
    check("rst_miss_count", 64'(miss_cnt[k]), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    c_ready = '0; cfg_hit = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset(1'b0);
    check_reset(1'b1);
    @(posedge clk); #1 rst = 1'b0;

    // Single read on requester 2 (hit); then write on 0 with 5 stall cycles (miss).
    one_txn(1'b0, 2'd2, 1'b0, 16'h1234, 32'h0, 1'b1, 16'd1, 16'd0, 0);
    one_txn(1'b0, 2'd0, 1'b1, 16'h0ABC, 32'h12345678, 1'b0, 16'd1, 16'd1, 5);

    // Round robin with all four requesters pending; 4-bit hit counter saturates at 15.
    do_reset();
    for (int unsigned i = 0; i < 16; i++) begin
      logic [1:0] w;
      w = 2'(i);
      push(1'b0, w, w[0], 16'(32'h1000 + 32'h111 * i[1:0]), 32'hA5A50000 | 32'(w), 1'b1,
           (i + 1 > 15) ? 16'd15 : 16'(i + 1), 16'd0, 1, 1);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      logic [1:0] w;
      w = 2'(i);
      set_slot(1'b0, w, w[0], 16'(32'h1000 + 32'h111 * i), 32'hA5A50000 | 32'(w));
    end
    cfg_hit[0] = 1'b1;
    @(posedge clk); #1;
    c_ready[0] = 1'b1;
    req_valid[0] = '1;
    cnt = 0;
    for (int unsigned i = 0; i < 200 && cnt < 16; i++) begin
      @(negedge clk);
      if (req_ready[0] != '0) cnt++;
    end
    @(posedge clk); #1 req_valid[0] = '0;
    check("rr_grants", 64'(cnt), 64'd16);
    wait_done(1'b0);
    for (int unsigned i = 0; i < 4; i++)
      one_txn(1'b0, 2'd2, 1'b0, 16'(32'h2000 + i), 32'h0, 1'b1, 16'd15, 16'd0, 0);

    // Reset while waiting for the cache: no response, counters cleared, pointer back to 0.
    push(1'b0, 2'd1, 1'b0, 16'h3333, 32'h0, 1'b1, 16'd0, 16'd0, 0, 1);
    set_slot(1'b0, 2'd1, 1'b0, 16'h3333, 32'h0);
    @(posedge clk); #1;
    c_ready[0] = 1'b1;
    req_valid[0][1] = 1'b1;
    wait_grant(1'b0);
    @(posedge clk); #1 req_valid[0] = '0;
    @(posedge clk); #1;
    check("busy_in_wait", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
      check("post_rst_busy", 64'(busy[0]), 64'd0);
    end
    check("post_rst_hit_count", 64'(hit_cnt[0]), 64'd0);
    check("post_rst_miss_count", 64'(miss_cnt[0]), 64'd0);
    push(1'b0, 2'd0, 1'b0, 16'h4444, 32'h0, 1'b1, 16'd1, 16'd0, 1, 1);
    set_slot(1'b0, 2'd0, 1'b0, 16'h4444, 32'h0);
    @(posedge clk); #1 req_valid[0] = '1;
    wait_grant(1'b0);
    @(posedge clk); #1 req_valid[0] = '0;
    wait_done(1'b0);

    // RSP_LAT=3 instance: write miss.
    one_txn(1'b1, 2'd1, 1'b1, 16'hBEEF, 32'hCAFEF00D, 1'b0, 16'd0, 16'd1, 0);

    if (exp_q.size() != 0) check("leftover_expectations", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
